// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with fill level, almost thresholds, sticky errors,
// and a compile-time choice of registered read or first-word-fall-through.
`default_nettype none
`timescale 1ns/1ps

module sync_fifo #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int AFULL_TH  = DEPTH - 2,
    parameter int AEMPTY_TH = 2,
    parameter int FWFT      = 0
) (
    input  logic                     clk,
    input  logic                     rst_l,
    input  logic                     write_en,
    input  logic [DATA_W-1:0]        write_data,
    input  logic                     read_en,
    input  logic                     clear_err,
    output logic [DATA_W-1:0]        read_data,
    output logic                     read_valid,
    output logic                     mem_full,
    output logic                     mem_empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   fill_level,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] c_PTR_ONE   = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] c_AFULL_TH  = AFULL_TH[ADDR_W:0];
    localparam logic [ADDR_W:0] c_AEMPTY_TH = AEMPTY_TH[ADDR_W:0];

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sync_fifo: DEPTH must be a power of two >= 2");
    end
    if (AFULL_TH < 0 || AFULL_TH > DEPTH || AEMPTY_TH < 0 || AEMPTY_TH > DEPTH) begin : g_bad_th
        $error("sync_fifo: thresholds must lie in 0..DEPTH");
    end

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W:0]   r_wr_ptr;
    logic [ADDR_W:0]   r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_full;
    logic              r_empty;
    logic              r_afull;
    logic              r_aempty;
    logic              r_overflow;
    logic              r_underflow;

    logic              w_wr_acc;
    logic              w_rd_acc;
    logic [ADDR_W:0]   w_wr_ptr_nxt;
    logic [ADDR_W:0]   w_rd_ptr_nxt;
    logic [ADDR_W:0]   w_count_nxt;
    logic              w_full_nxt;
    logic              w_empty_nxt;

    // Acceptance looks only at registered flags, so a write into an empty FIFO is never bypassed.
    assign w_wr_acc     = write_en && !r_full;
    assign w_rd_acc     = read_en && !r_empty;
    assign w_wr_ptr_nxt = w_wr_acc ? r_wr_ptr + c_PTR_ONE : r_wr_ptr;
    assign w_rd_ptr_nxt = w_rd_acc ? r_rd_ptr + c_PTR_ONE : r_rd_ptr;
    assign w_full_nxt   = (w_wr_ptr_nxt[ADDR_W] != w_rd_ptr_nxt[ADDR_W]) &&
                          (w_wr_ptr_nxt[ADDR_W-1:0] == w_rd_ptr_nxt[ADDR_W-1:0]);
    assign w_empty_nxt  = (w_wr_ptr_nxt == w_rd_ptr_nxt);

    always_comb begin
        w_count_nxt = r_count;
        case ({w_wr_acc, w_rd_acc})
            2'b10:   w_count_nxt = r_count + c_PTR_ONE;
            2'b01:   w_count_nxt = r_count - c_PTR_ONE;
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_full      <= 1'b0;
            r_empty     <= 1'b1;
            r_afull     <= 1'b0;
            r_aempty    <= 1'b1;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_wr_ptr    <= w_wr_ptr_nxt;
            r_rd_ptr    <= w_rd_ptr_nxt;
            r_count     <= w_count_nxt;
            r_full      <= w_full_nxt;
            r_empty     <= w_empty_nxt;
            r_afull     <= (w_count_nxt >= c_AFULL_TH);
            r_aempty    <= (w_count_nxt <= c_AEMPTY_TH);
            // A new error event outranks a coincident clear.
            r_overflow  <= (write_en && r_full) || (r_overflow && !clear_err);
            r_underflow <= (read_en && r_empty) || (r_underflow && !clear_err);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr[ADDR_W-1:0]] <= write_data;
        end
    end

    if (FWFT != 0) begin : g_fwft
        assign read_valid = !r_empty;
        assign read_data  = r_empty ? '0 : r_mem[r_rd_ptr[ADDR_W-1:0]];
    end else begin : g_std
        logic [DATA_W-1:0] r_rdata;
        logic              r_rvalid;

        always_ff @(posedge clk or negedge rst_l) begin
            if (!rst_l) begin
                r_rdata  <= '0;
                r_rvalid <= 1'b0;
            end else begin
                r_rvalid <= w_rd_acc;
                if (w_rd_acc) begin
                    r_rdata <= r_mem[r_rd_ptr[ADDR_W-1:0]];
                end
            end
        end

        assign read_valid = r_rvalid;
        assign read_data  = r_rdata;
    end

    assign mem_full     = r_full;
    assign mem_empty    = r_empty;
    assign almost_full  = r_afull;
    assign almost_empty = r_aempty;
    assign fill_level   = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule

`default_nettype wire

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
- Single-clock, parametrised successor to the existing FIFO: configurable data width and depth, fill-level reporting, programmable almost-full/almost-empty thresholds, and sticky overflow/underflow error flags.
- A compile-time mode selects standard registered read (1-cycle latency) or first-word-fall-through (FWFT).
- Used as the general buffering primitive between same-clock pipeline stages.

Parameters:
- DATA_W, 8: width of write_data/read_data in bits.
- DEPTH, 16: number of entries; power of two, >= 2. ADDR_W = log2(DEPTH).
- AFULL_TH, DEPTH-2: almost_full asserts when count >= AFULL_TH.
- AEMPTY_TH, 2: almost_empty asserts when count <= AEMPTY_TH.
- FWFT, 0: 0 = standard registered read; 1 = first-word-fall-through.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_l  in  1  asynchronous, active-low reset.
- write_en  in  1  write request.
- write_data  in  DATA_W  data to write.
- read_en  in  1  read/pop request.
- clear_err  in  1  synchronous clear of the sticky error flags.
- read_data  out  DATA_W  read data.
- read_valid  out  1  read_data is valid.
- mem_full  out  1  count == DEPTH.
- mem_empty  out  1  count == 0.
- almost_full  out  1  count >= AFULL_TH.
- almost_empty  out  1  count <= AEMPTY_TH.
- fill_level  out  ADDR_W+1  current count, 0..DEPTH.
- overflow  out  1  sticky: a write was attempted while full.
- underflow  out  1  sticky: a read was attempted while empty.

Behaviour:
- Reset (rst_l low, asynchronous, held while low):
  - Pointers = 0, fill_level = 0, mem_empty = 1, almost_empty = 1.
  - mem_full = 0, almost_full = 0, overflow = 0, underflow = 0, read_valid = 0, read_data = 0.
  - Storage contents are don't-care.
- Pointers: wr_ptr and rd_ptr are ADDR_W+1 bits.
  - The low ADDR_W bits index storage.
  - The MSB toggles on each wrap.
  - Full: MSBs differ and low bits are equal. Empty: pointers are equal.
- Accept rules, evaluated on current registered flags:
  - Write accepted iff write_en && !mem_full.
  - Read accepted iff read_en && !mem_empty.
  - No bypass: a write to an empty FIFO is not readable until the following cycle.
- Counting and flags:
  - fill_level +1 on write-only accept, -1 on read-only accept, unchanged when both or neither are accepted.
  - All flags are registered and reflect the post-edge count in the same cycle fill_level updates.
- Standard mode (FWFT=0):
  - On an accepted read, read_data <= mem[rd_ptr] and read_valid = 1 on the next cycle (1-cycle latency).
  - read_valid is 0 in cycles with no accepted read.
  - read_data holds its last value otherwise.
- FWFT mode (FWFT=1):
  - read_data = head entry and read_valid = !mem_empty, valid in the same cycle the entry becomes visible.
  - read_en acts as a pop/acknowledge; the next entry appears the cycle after the pop.
- Simultaneous read and write:
  - Not full and not empty: both accepted, count unchanged.
  - Full: read accepted, write dropped, overflow set.
  - Empty: write accepted; the read is dropped and sets underflow.
- Errors:
  - overflow is set on write_en && mem_full; underflow is set on read_en && mem_empty.
  - Both are sticky until clear_err.
  - If clear_err coincides with a new error event, the flag stays set (set wins).
- Wrap-around: pointers wrap modulo 2*DEPTH with no gap. Data order is preserved across any number of wraps.
- Parameter checks: elaboration fails if DEPTH is not a power of two, or if AFULL_TH/AEMPTY_TH fall outside 0..DEPTH.

Test Plan (DEPTH=16, DATA_W=8, default thresholds, both FWFT settings):
- Reset, then write 0x00..0x0F with read_en=0 -> mem_full=1 after the 16th write; fill_level=16; almost_full from count 14; a 17th write sets overflow=1 and fill_level stays 16.
- Read 16 entries from full -> data 0x00..0x0F in order (FWFT=0: each valid one cycle after read_en); mem_empty=1 at end; a further read sets underflow=1.
- Continuous simultaneous write/read at count 8 for 40 cycles -> fill_level constant at 8, order preserved across pointer wraps, no error flags.
- Simultaneous write/read while full, then while empty -> full: read accepted and write dropped with overflow=1; empty: write accepted (fill_level=1) and underflow=1.
- Pulse clear_err with no event -> flags clear next cycle; clear_err coincident with an overflowing write -> overflow stays 1.
- Assert rst_l low mid-burst at count 5 -> all outputs return to reset values immediately, without waiting for a clock edge; after release, the first write/read round-trips correctly.
